lcd_char_driver: RTL and testbench
==================================

// Module: lcd_char_driver
// PURPOSE
//  Consumer end of the processor's lcd_write/lcd_data output port.
//  Queues processor writes in a small FIFO and replays them onto an HD44780-style
//  8-bit character LCD bus (DB/RS/RW/EN), including the timed power-up init sequence.
//  Lets the processor issue one lcd_write per cycle without any LCD timing awareness.
// PARAMETERS
//  FIFO_DEPTH      16      entries in the write queue (power of 2, >=2)
//  POWERUP_CYCLES  750000  wait after reset before the first init command (15 ms @ 50 MHz)
//  SETUP_CYCLES    4       RS/DB stable before EN rises
//  EN_CYCLES       25      EN high width
//  HOLD_CYCLES     4       RS/DB held after EN falls
//  EXEC_CYCLES     2500    post-transfer wait, ordinary command or character
//  CLEAR_CYCLES    82000   post-transfer wait for command bytes 0x01 and 0x02
// PORTS
//  clock         in   1   system clock; all state changes on rising edge
//  reset         in   1   asynchronous, active-high; clears all state
//  lcd_write     in   1   one-cycle write strobe from processor
//  lcd_data      in   32  [8]=RS (0 command, 1 character), [7:0]=byte, [31:9] ignored
//  lcd_full      out  1   FIFO holds FIFO_DEPTH entries
//  lcd_overflow  out  1   sticky: a write was dropped
//  lcd_ready     out  1   init sequence complete
//  lcd_db        out  8   LCD data bus
//  lcd_rs        out  1   LCD register select
//  lcd_rw        out  1   constant 0 (write only)
//  lcd_en        out  1   LCD enable strobe
// BEHAVIOUR
//  Reset (async, any state): all outputs 0; FIFO emptied; FSM -> POWERUP; cycle counter cleared.
//  FSM: POWERUP -> INIT -> IDLE -> SETUP -> PULSE -> HOLD -> WAIT -> (INIT | IDLE | SETUP).
//   POWERUP: count POWERUP_CYCLES, then load init byte 0.
//   INIT: issues 0x38, 0x0C, 0x01, 0x06 (RS=0) in order, each via SETUP/PULSE/HOLD/WAIT.
//     lcd_ready rises the cycle WAIT of 0x06 ends; stays 1 until reset.
//   IDLE: FIFO non-empty -> pop head, latch DB/RS, go SETUP in the next cycle.
//   SETUP: SETUP_CYCLES, EN=0. PULSE: EN_CYCLES, EN=1. HOLD: HOLD_CYCLES, EN=0.
//   WAIT: CLEAR_CYCLES if RS=0 and byte is 0x01 or 0x02, else EXEC_CYCLES.
//     At end of WAIT, if the FIFO is non-empty, pop and go directly to SETUP (no IDLE bubble).
//  DB/RS change only on entry to SETUP; constant through PULSE and HOLD.
//  FIFO: writes are accepted in every state, including POWERUP and INIT.
//   Accept if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
//   Otherwise drop the write and set lcd_overflow.
//   Pointers wrap modulo FIFO_DEPTH.
//   lcd_full is registered and reflects the count after the current cycle's push/pop.
//  Latency: a write in IDLE after init puts EN high 1+1+SETUP_CYCLES cycles later.
//  Counters: 20-bit minimum; a phase of N cycles lasts exactly N clocks.
// CONFIGURATION
//  LCD_LINE_WRAP_EN defined:
//   Track the DDRAM column of a 2x16 display.
//   After the 16th character on line 1, insert command 0xC0 before the next character.
//   After the 16th character on line 2, insert command 0x80 before the next character.
//   An inserted command uses a full SETUP..WAIT slot and pops nothing.
//   Column resets to line 1, column 0 on reset, and on commands 0x01, 0x02, or 0x80.
//   Command 0xC0 sets line 2, column 0.
//  Not defined: bytes pass through verbatim; no column tracking logic is generated.
// STRUCTURE
//  lcd_defs.vh: FSM state encodings, the init command table, CMD_CLEAR/CMD_HOME/
//   CMD_LINE1/CMD_LINE2 constants.
//  Sub-module lcd_fifo: 9-bit wide, FIFO_DEPTH deep, synchronous push/pop,
//   count/full/empty outputs, async reset.
//  Top holds the FSM, the phase counter, and the optional wrap tracker.
// TESTING (small params: POWERUP=20, SETUP=2, EN=3, HOLD=2, EXEC=5, CLEAR=10)
//  Reset release -> EN=0 for 20 cycles, then 4 pulses with DB 0x38,0x0C,0x01,0x06, RS=0;
//   lcd_ready=1 after the last WAIT.
//  lcd_write with lcd_data=0x141 after ready -> one pulse, DB=0x41, RS=1, EN high exactly 3 cycles.
//  17 back-to-back writes during POWERUP -> first 16 queued, 17th dropped, lcd_overflow=1,
//   lcd_full=1 until the first pop.
//  Command 0x001 -> following WAIT lasts 10 cycles; character 0x141 -> WAIT lasts 5.
//  Assert reset during PULSE -> lcd_en=0 the same cycle; FIFO empty; init restarts from POWERUP.
//  With LCD_LINE_WRAP_EN: 17 chars 'A' -> 16 RS=1 pulses, then RS=0 DB=0xC0, then the 17th 'A'.
//   Without the macro: 17 consecutive RS=1 pulses.

Source files
------------

// File: rtl/lcd_char_driver_pkg.sv
// lcd_char_driver_pkg: FSM states, HD44780 command constants and init table for lcd_char_driver
package lcd_char_driver_pkg;

    typedef enum logic [2:0] {
        S_POWERUP,
        S_INIT,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_LINE1 = 8'h80;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;

    // 8-bit/2-line, display on, clear, entry mode increment
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        return idx == 2'd0 ? 8'h38 : idx == 2'd1 ? 8'h0C : idx == 2'd2 ? CMD_CLEAR : 8'h06;
    endfunction

    // clear and home need the long execution wait
    function automatic logic is_slow(input logic rs, input logic [7:0] b);
        return !rs && (b == CMD_CLEAR || b == CMD_HOME);
    endfunction

endpackage

// File: rtl/lcd_char_driver_fifo.sv
// lcd_char_driver_fifo: 9-bit show-ahead write queue {rs, byte}; a push into a full queue is accepted only alongside a pop
module lcd_char_driver_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [8:0]               din,
    output logic [8:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [AW:0]   count_next;

    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign dout       = mem[rd_ptr];

    // pointers wrap naturally at DEPTH; full/empty registered from the post-update count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= count_next == (AW+1)'(DEPTH);
            empty <= count_next == '0;
        end
    end

    // storage needs no reset; the pointers define what is valid
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/lcd_char_driver.sv
// lcd_char_driver: queues processor LCD writes and replays them on an HD44780 8-bit bus with power-up init; LCD_LINE_WRAP_EN adds 2x16 line wrap
module lcd_char_driver
    import lcd_char_driver_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int POWERUP_CYCLES = 750000,
    parameter int SETUP_CYCLES   = 4,
    parameter int EN_CYCLES      = 25,
    parameter int HOLD_CYCLES    = 4,
    parameter int EXEC_CYCLES    = 2500,
    parameter int CLEAR_CYCLES   = 82000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        lcd_write,
    input  logic [31:0] lcd_data,
    output logic        lcd_full,
    output logic        lcd_overflow,
    output logic        lcd_ready,
    output logic [7:0]  lcd_db,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BIG = POWERUP_CYCLES > CLEAR_CYCLES ? POWERUP_CYCLES : CLEAR_CYCLES;
    localparam int CW  = $clog2(BIG + 1) > 20 ? $clog2(BIG + 1) : 20;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wait_len;
    logic [1:0]    init_idx;
    logic [8:0]    head;
    logic [AW:0]   count;
    logic          empty;
    logic          phase_last;
    logic          to_init;
    logic          take;
    logic          pop;
    logic          load;
    logic [8:0]    load_item;
    logic          need_wrap;
    logic [7:0]    wrap_cmd;
    logic          unused_hi;

    assign unused_hi = ^lcd_data[31:9];
    assign lcd_rw    = 1'b0;

    lcd_char_driver_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (lcd_write),
        .pop   (pop),
        .din   (lcd_data[8:0]),
        .dout  (head),
        .count (count),
        .full  (lcd_full),
        .empty (empty)
    );

    assign wait_len   = is_slow(lcd_rs, lcd_db) ? CW'(CLEAR_CYCLES - 1) : CW'(EXEC_CYCLES - 1);
    assign phase_last = cnt == (state == S_POWERUP ? CW'(POWERUP_CYCLES - 1) :
                                state == S_SETUP   ? CW'(SETUP_CYCLES - 1)   :
                                state == S_PULSE   ? CW'(EN_CYCLES - 1)      :
                                state == S_HOLD    ? CW'(HOLD_CYCLES - 1)    : wait_len);
    assign to_init    = !lcd_ready && init_idx != 2'd3;
    // a slot is taken from IDLE, or straight from the end of WAIT to avoid an idle bubble
    assign take       = !empty && (state == S_IDLE || (state == S_WAIT && phase_last && !to_init));
    assign pop        = take && !need_wrap;
    assign load       = take || state == S_INIT;
    assign load_item  = state == S_INIT ? {1'b0, init_cmd(init_idx)} :
                        need_wrap       ? {1'b0, wrap_cmd}           : head;

`ifdef LCD_LINE_WRAP_EN
    logic [4:0] col;
    logic       line2;

    assign need_wrap = head[8] && col == 5'd16;
    assign wrap_cmd  = line2 ? CMD_LINE1 : CMD_LINE2;

    // follow the DDRAM cursor through every byte actually sent to the display
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col   <= '0;
            line2 <= 1'b0;
        end else if (load) begin
            if (load_item[8]) begin
                col <= col + 1'b1;
            end else if (load_item[7:0] == CMD_CLEAR || load_item[7:0] == CMD_HOME || load_item[7:0] == CMD_LINE1) begin
                col   <= '0;
                line2 <= 1'b0;
            end else if (load_item[7:0] == CMD_LINE2) begin
                col   <= '0;
                line2 <= 1'b1;
            end
        end
    end
`else
    assign need_wrap = 1'b0;
    assign wrap_cmd  = CMD_LINE1;
`endif

    // sticky flag for a write that found the queue full with no pop to make room
    always_ff @(posedge clock or posedge reset) begin
        if (reset) lcd_overflow <= 1'b0;
        else if (lcd_write && count == (AW+1)'(FIFO_DEPTH) && !pop) lcd_overflow <= 1'b1;
    end

    // bus sequencer: power-up wait, init table, then one SETUP/PULSE/HOLD/WAIT slot per byte
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_POWERUP;
            cnt       <= '0;
            init_idx  <= '0;
            lcd_db    <= '0;
            lcd_rs    <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_ready <= 1'b0;
        end else begin
            cnt <= (phase_last || state == S_INIT || state == S_IDLE) ? '0 : cnt + 1'b1;
            if (load) begin
                lcd_db <= load_item[7:0];
                lcd_rs <= load_item[8];
            end
            case (state)
                S_POWERUP: if (phase_last) state <= S_INIT;
                S_INIT:    state <= S_SETUP;
                S_IDLE:    if (take) state <= S_SETUP;
                S_SETUP: if (phase_last) begin
                    state  <= S_PULSE;
                    lcd_en <= 1'b1;
                end
                S_PULSE: if (phase_last) begin
                    state  <= S_HOLD;
                    lcd_en <= 1'b0;
                end
                S_HOLD:    if (phase_last) state <= S_WAIT;
                S_WAIT: if (phase_last) begin
                    if (to_init) begin
                        init_idx <= init_idx + 1'b1;
                        state    <= S_INIT;
                    end else begin
                        lcd_ready <= 1'b1;
                        state     <= take ? S_SETUP : S_IDLE;
                    end
                end
                default:   state <= S_POWERUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_char_driver.sv
// tb_lcd_char_driver: randomized bench for lcd_char_driver with a pulse monitor and a byte-stream reference model
module tb_lcd_char_driver;
    localparam int DEPTH = 16, PWR = 20, SETUP = 2, ENW = 3, HOLD = 2, EXEC = 5, CLEAR = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        lcd_write = 1'b0;
    logic [31:0] lcd_data = '0;
    logic        lcd_full, lcd_overflow, lcd_ready, lcd_rs, lcd_rw, lcd_en;
    logic [7:0]  lcd_db;

    always #5 clock = ~clock;

    lcd_char_driver #(
        .FIFO_DEPTH(DEPTH), .POWERUP_CYCLES(PWR), .SETUP_CYCLES(SETUP), .EN_CYCLES(ENW),
        .HOLD_CYCLES(HOLD), .EXEC_CYCLES(EXEC), .CLEAR_CYCLES(CLEAR)
    ) dut (
        .clock(clock), .reset(reset), .lcd_write(lcd_write), .lcd_data(lcd_data),
        .lcd_full(lcd_full), .lcd_overflow(lcd_overflow), .lcd_ready(lcd_ready),
        .lcd_db(lcd_db), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
    );

    typedef struct {
        logic [8:0] d;
        int         w;
        int         gap;
        bit         ok;
    } pulse_t;

    pulse_t     cap[$];
    pulse_t     cur;
    logic [8:0] exp_q[$];
    bit         en_q = 1'b0;
    int         low = 0;
    int         tests = 0, fails = 0, chk = 0;
    int         col = 0, line = 1;

    // capture every EN pulse: {rs,db} at rise, width, preceding low time, bus stability
    always @(negedge clock) begin
        if (lcd_en && !en_q) begin
            cur.d = {lcd_rs, lcd_db}; cur.w = 1; cur.gap = low; cur.ok = 1'b1;
        end else if (lcd_en) begin
            cur.w = cur.w + 1;
            if ({lcd_rs, lcd_db} !== cur.d) cur.ok = 1'b0;
        end else if (en_q) begin
            cap.push_back(cur);
            low = 0;
        end
        if (!lcd_en) low = low + 1;
        en_q = lcd_en;
    end

    // reference: the byte stream the display must see, with column bookkeeping for line wrap
    function automatic void emit(input logic [8:0] x);
        exp_q.push_back(x);
        if (x[8]) col = col + 1;
        else if (x[7:0] == 8'h01 || x[7:0] == 8'h02 || x[7:0] == 8'h80) begin col = 0; line = 1; end
        else if (x[7:0] == 8'hC0) begin col = 0; line = 2; end
    endfunction

    function automatic void model_write(input logic [8:0] x);
`ifdef LCD_LINE_WRAP_EN
        if (x[8] && col == 16) emit(line == 1 ? 9'h0C0 : 9'h080);
`endif
        emit(x);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        lcd_write = 1'b0;
        repeat (2) @(negedge clock);
        cap.delete();
        exp_q.delete();
        chk = 0; col = 0; line = 1;
        emit(9'h038); emit(9'h00C); emit(9'h001); emit(9'h006);
        reset = 1'b0;
    endtask

    task automatic wait_cap(input int n, input int budget, output bit ok);
        int i = 0;
        while (cap.size() < n && i < budget) begin
            @(negedge clock); #1;
            i++;
        end
        ok = cap.size() >= n;
    endtask

    task automatic wr(input logic [8:0] x);
        lcd_data = $urandom();
        lcd_data[8:0] = x;
        lcd_write = 1'b1;
        @(negedge clock);
        lcd_write = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int k = 0;
        while (!lcd_ready && k < budget) begin @(negedge clock); k++; end
        tests++;
        if (lcd_ready !== 1'b1) begin fails++; $display("FAIL ready_timeout: lcd_ready=%b want 1", lcd_ready); end
    endtask

    task automatic test_reset();
        int viol = 0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests++;
        if ({lcd_en, lcd_db, lcd_rs, lcd_rw, lcd_ready, lcd_full, lcd_overflow} !== 14'b0) begin
            fails++;
            $display("FAIL reset_outputs: en=%b db=%h rs=%b rw=%b ready=%b full=%b ovf=%b want all 0",
                     lcd_en, lcd_db, lcd_rs, lcd_rw, lcd_ready, lcd_full, lcd_overflow);
        end
        do_reset();
        for (int i = 0; i < PWR; i++) begin
            @(negedge clock);
            if (lcd_en !== 1'b0) viol++;
        end
        tests++;
        if (viol != 0) begin fails++; $display("FAIL powerup_en_low: %0d cycles with EN high, want 0", viol); end
    endtask

    task automatic test_init();
        bit ok;
        int k = 0;
        wait_cap(4, 300, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL init_timeout: got %0d pulses want 4", cap.size()); end
        for (int i = 0; i < 4 && i < cap.size(); i++) begin
            tests++;
            if (cap[i].d !== exp_q[i] || cap[i].w != ENW || !cap[i].ok) begin
                fails++;
                $display("FAIL init_cmd%0d: got d=%h w=%0d stable=%0d want d=%h w=%0d stable=1",
                         i, cap[i].d, cap[i].w, cap[i].ok, exp_q[i], ENW);
            end
        end
        tests++;
        if (lcd_ready !== 1'b0) begin fails++; $display("FAIL ready_early: lcd_ready=%b want 0", lcd_ready); end
        while (!lcd_ready && k < 40) begin @(negedge clock); k++; end
        tests++;
        if (k != HOLD + EXEC) begin fails++; $display("FAIL ready_time: rose %0d cycles after EN fall want %0d", k, HOLD + EXEC); end
        chk = 4;
    endtask

    task automatic test_single_char();
        bit ok;
        int k;
        repeat (20) @(negedge clock);
        model_write(9'h141);
        wr(9'h141);
        k = 1;
        while (!lcd_en && k < 50) begin @(negedge clock); k++; end
        tests++;
        if (k != 2 + SETUP) begin fails++; $display("FAIL write_latency: EN high after %0d cycles want %0d", k, 2 + SETUP); end
        wait_cap(exp_q.size(), 100, ok);
        tests++;
        if (!ok || cap[chk].d !== 9'h141 || cap[chk].w != ENW || !cap[chk].ok) begin
            fails++;
            $display("FAIL single_char: got %0d pulses d=%h w=%0d want d=141 w=%0d",
                     cap.size(), ok ? cap[chk].d : 9'h0, ok ? cap[chk].w : 0, ENW);
        end
        chk = exp_q.size();
    endtask

    task automatic test_wait_len();
        bit ok;
        logic [8:0] seq [3] = '{9'h001, 9'h141, 9'h141};
        int gaps [3] = '{0, HOLD + CLEAR + SETUP, HOLD + EXEC + SETUP};
        foreach (seq[i]) model_write(seq[i]);
        foreach (seq[i]) wr(seq[i]);
        wait_cap(exp_q.size(), 300, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL wait_len_timeout: got %0d pulses want %0d", cap.size(), exp_q.size()); end
        for (int i = 0; i < 3 && ok; i++) begin
            tests++;
            if (cap[chk+i].d !== exp_q[chk+i] || cap[chk+i].w != ENW || (i > 0 && cap[chk+i].gap != gaps[i])) begin
                fails++;
                $display("FAIL wait_len%0d: got d=%h w=%0d gap=%0d want d=%h w=%0d gap=%0d",
                         i, cap[chk+i].d, cap[chk+i].w, cap[chk+i].gap, exp_q[chk+i], ENW, gaps[i]);
            end
        end
        chk = exp_q.size();
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] cmds [6] = '{8'h01, 8'h02, 8'h80, 8'hC0, 8'h0C, 8'h06};
        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) begin
                logic [8:0] x;
                if ($urandom_range(0, 4) != 0) x = {1'b1, 8'($urandom_range(8'h20, 8'h7E))};
                else x = {1'b0, $urandom_range(0, 1) == 1 ? cmds[$urandom_range(0, 5)] : 8'($urandom())};
                model_write(x);
                wr(x);
                repeat ($urandom_range(0, 3)) @(negedge clock);
            end
            wait_cap(exp_q.size(), 2000, ok);
            repeat (30) @(negedge clock);
            tests++;
            if (cap.size() != exp_q.size()) begin
                fails++; $display("FAIL rnd%0d_count: got %0d pulses want %0d", r, cap.size(), exp_q.size());
            end
            for (int i = chk; i < exp_q.size() && i < cap.size(); i++) begin
                tests++;
                if (cap[i].d !== exp_q[i] || cap[i].w != ENW || !cap[i].ok) begin
                    fails++;
                    $display("FAIL rnd%0d_pulse%0d: got d=%h w=%0d stable=%0d want d=%h w=%0d stable=1",
                             r, i, cap[i].d, cap[i].w, cap[i].ok, exp_q[i], ENW);
                end
            end
            chk = exp_q.size();
        end
        tests++;
        if (lcd_overflow !== 1'b0) begin fails++; $display("FAIL rnd_overflow: lcd_overflow=%b want 0", lcd_overflow); end
    endtask

    task automatic test_wrap();
        bit ok;
        int chars = 0;
        do_reset();
        wait_ready(400);
        chk = 4;
        repeat (17) model_write(9'h141);
        repeat (17) wr(9'h141);
        wait_cap(exp_q.size(), 1000, ok);
        repeat (30) @(negedge clock);
        tests++;
`ifdef LCD_LINE_WRAP_EN
        if (cap.size() != 4 + 18) begin fails++; $display("FAIL wrap_count: got %0d pulses want %0d", cap.size(), 22); end
`else
        if (cap.size() != 4 + 17) begin fails++; $display("FAIL wrap_count: got %0d pulses want %0d", cap.size(), 21); end
`endif
        for (int i = chk; i < exp_q.size() && i < cap.size(); i++) begin
            if (cap[i].d[8]) chars++;
            tests++;
            if (cap[i].d !== exp_q[i] || cap[i].w != ENW) begin
                fails++;
                $display("FAIL wrap_pulse%0d: got d=%h w=%0d want d=%h w=%0d", i, cap[i].d, cap[i].w, exp_q[i], ENW);
            end
        end
        tests++;
        if (chars != 17 || lcd_overflow !== 1'b0) begin
            fails++; $display("FAIL wrap_chars: got %0d chars ovf=%b want 17 chars ovf=0", chars, lcd_overflow);
        end
        chk = exp_q.size();
    endtask

    task automatic test_overflow();
        bit ok;
        int viol = 0, k = 0;
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            logic [8:0] x = {1'($urandom_range(0, 1)), 8'($urandom())};
            if (i < DEPTH) model_write(x);
            wr(x);
        end
        tests++;
        if (lcd_overflow !== 1'b1 || lcd_full !== 1'b1) begin
            fails++; $display("FAIL ovf_flags: ovf=%b full=%b want 1 1", lcd_overflow, lcd_full);
        end
        while (!lcd_ready && k < 400) begin
            if (lcd_full !== 1'b1) viol++;
            @(negedge clock); k++;
        end
        tests++;
        if (viol != 0 || lcd_ready !== 1'b1 || lcd_full !== 1'b0) begin
            fails++;
            $display("FAIL full_until_pop: %0d early drops ready=%b full_at_pop=%b want 0 1 0", viol, lcd_ready, lcd_full);
        end
        wait_cap(exp_q.size(), 3000, ok);
        repeat (30) @(negedge clock);
        tests++;
        if (cap.size() != exp_q.size()) begin fails++; $display("FAIL ovf_count: got %0d pulses want %0d", cap.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            tests++;
            if (cap[i].d !== exp_q[i] || cap[i].w != ENW) begin
                fails++;
                $display("FAIL ovf_pulse%0d: got d=%h w=%0d want d=%h w=%0d", i, cap[i].d, cap[i].w, exp_q[i], ENW);
            end
        end
        tests++;
        if (lcd_overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: lcd_overflow=%b want 1", lcd_overflow); end
    endtask

    task automatic test_reset_pulse();
        bit ok;
        int k = 0;
        do_reset();
        repeat (DEPTH + 1) wr({1'b1, 8'h5A});
        while (!lcd_en && k < 200) begin @(negedge clock); k++; end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({lcd_en, lcd_overflow, lcd_full, lcd_ready} !== 4'b0) begin
            fails++;
            $display("FAIL async_reset: en=%b ovf=%b full=%b ready=%b want 0 0 0 0", lcd_en, lcd_overflow, lcd_full, lcd_ready);
        end
        do_reset();
        wait_cap(4, 300, ok);
        repeat (200) @(negedge clock);
        tests++;
        if (cap.size() != 4 || lcd_ready !== 1'b1) begin
            fails++; $display("FAIL restart: got %0d pulses ready=%b want 4 pulses ready=1", cap.size(), lcd_ready);
        end
        for (int i = 0; i < 4 && i < cap.size(); i++) begin
            tests++;
            if (cap[i].d !== exp_q[i]) begin fails++; $display("FAIL restart_cmd%0d: got %h want %h", i, cap[i].d, exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_single_char();
        test_wait_len();
        test_random();
        test_wrap();
        test_overflow();
        test_reset_pulse();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
